// File: rtl/mo_line_scheduler_pkg.sv
// Shared definitions for the motion-object line scheduler: FSM states, object
// geometry, sprite RAM field offsets and the object byte-address helper.
package mo_line_scheduler_pkg;

    localparam int OBJ_BYTES = 4;
    localparam int OBJ_H     = 16;
    localparam int OBJ_W     = 8;

    typedef enum logic [1:0] {
        OFS_CODE = 2'd0,
        OFS_Y    = 2'd1,
        OFS_ATTR = 2'd2,
        OFS_X    = 2'd3
    } obj_field_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_Y  = 4'd1,
        ST_CHK_Y   = 4'd2,
        ST_ADDR_C  = 4'd3,
        ST_LAT_C   = 4'd4,
        ST_LAT_X   = 4'd5,
        ST_ROM_LAT = 4'd6,
        ST_PIX0    = 4'd7,
        ST_PIX1    = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    function automatic logic [7:0] obj_byte(input logic [7:0] base,
                                            input logic [5:0] idx,
                                            input obj_field_t ofs);
        return base + 8'(idx * OBJ_BYTES) + 8'(ofs);
    endfunction

endpackage

// File: rtl/mo_line_scheduler_row_match.sv
// Combinational vertical hit test: an object at Y covers target line tl when
// the 8-bit difference tl - Y falls inside the object height.
module mo_row_match
    import mo_line_scheduler_pkg::*;
(
    input  logic [7:0] tl,
    input  logic [7:0] y,
    output logic       hit,
    output logic [3:0] row
);

    logic [7:0] diff;

    assign diff = tl - y;
    assign hit  = (diff < 8'(OBJ_H));
    assign row  = diff[3:0];

endmodule

// File: rtl/mo_line_scheduler.sv
// Motion-object line scheduler: scans sprite RAM one line ahead and writes the
// opaque pixels of every intersecting object into the idle line-buffer half.
module mo_line_scheduler
    import mo_line_scheduler_pkg::*;
#(
    parameter int         NUM_OBJ  = 40,
    parameter logic [7:0] OBJ_BASE = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        hblank_start,
    input  logic        vblank,
    input  logic [7:0]  vcount,
    input  logic        buf1buf2n,
    output logic [8:0]  mo_addr,
    input  logic [7:0]  mo_data,
    output logic [13:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        lb_we,
    output logic        lb_sel,
    output logic [7:0]  lb_addr,
    output logic [3:0]  lb_data,
    output logic        busy,
    output logic        overrun
);

    localparam logic [5:0] I_LAST = 6'(NUM_OBJ - 1);
    localparam logic [1:0] K_LAST = 2'(OBJ_W / 2 - 1);

    state_t      state_reg, state_next;
    logic [5:0]  i_reg, i_next;
    logic [1:0]  k_reg, k_next;
    logic [7:0]  tl_reg, tl_next;
    logic [7:0]  code_reg, code_next;
    logic [7:0]  x_reg, x_next;
    logic [7:0]  pix_reg, pix_next;
    logic [3:0]  row_reg, row_next;
    logic        bank_reg, bank_next;
    logic        lb_sel_reg, lb_sel_next;
    logic        overrun_reg, overrun_next;
    logic [8:0]  mo_addr_reg, mo_addr_next;
    logic [13:0] rom_addr_reg, rom_addr_next;

    logic        hit;
    logic [3:0]  row_hit;
    logic        to_done;
    logic        pix_state;
    logic [3:0]  nibble;
    logic [8:0]  x9;

    mo_row_match u_row_match (
        .tl  (tl_reg),
        .y   (mo_data),
        .hit (hit),
        .row (row_hit)
    );

    assign busy = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

    always_comb begin
        state_next    = state_reg;
        i_next        = i_reg;
        k_next        = k_reg;
        tl_next       = tl_reg;
        code_next     = code_reg;
        x_next        = x_reg;
        pix_next      = pix_reg;
        row_next      = row_reg;
        bank_next     = bank_reg;
        lb_sel_next   = lb_sel_reg;
        overrun_next  = overrun_reg;
        mo_addr_next  = mo_addr_reg;
        rom_addr_next = rom_addr_reg;
        to_done       = 1'b0;

        // Addresses are registered one state ahead so memory data lands in the consuming state.
        case (state_reg)
            ST_IDLE, ST_DONE: ;
            ST_ADDR_Y:  state_next = ST_CHK_Y;
            ST_CHK_Y: begin
                if (hit) begin
                    row_next     = row_hit;
                    mo_addr_next = {bank_reg, obj_byte(OBJ_BASE, i_reg, OFS_CODE)};
                    state_next   = ST_ADDR_C;
                end else if (i_reg == I_LAST) begin
                    to_done    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    i_next       = i_reg + 6'd1;
                    mo_addr_next = {bank_reg, obj_byte(OBJ_BASE, i_reg + 6'd1, OFS_Y)};
                    state_next   = ST_ADDR_Y;
                end
            end
            ST_ADDR_C: begin
                mo_addr_next = {bank_reg, obj_byte(OBJ_BASE, i_reg, OFS_X)};
                state_next   = ST_LAT_C;
            end
            ST_LAT_C: begin
                code_next     = mo_data;
                rom_addr_next = {mo_data, row_reg, 2'd0};
                state_next    = ST_LAT_X;
            end
            ST_LAT_X: begin
                x_next     = mo_data;
                state_next = ST_ROM_LAT;
            end
            ST_ROM_LAT: begin
                pix_next   = rom_data;
                state_next = ST_PIX0;
            end
            ST_PIX0: begin
                if (k_reg != K_LAST)
                    rom_addr_next = {code_reg, row_reg, k_reg + 2'd1};
                state_next = ST_PIX1;
            end
            ST_PIX1: begin
                if (k_reg != K_LAST) begin
                    k_next     = k_reg + 2'd1;
                    state_next = ST_ROM_LAT;
                end else begin
                    k_next = 2'd0;
                    if (i_reg == I_LAST) begin
                        to_done    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        i_next       = i_reg + 6'd1;
                        mo_addr_next = {bank_reg, obj_byte(OBJ_BASE, i_reg + 6'd1, OFS_Y)};
                        state_next   = ST_ADDR_Y;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A scan that is about to enter DONE on this edge has finished in time.
        if (hblank_start) begin
            lb_sel_next  = ~lb_sel_reg;
            i_next       = 6'd0;
            k_next       = 2'd0;
            overrun_next = busy && !to_done;
            if (!vblank) begin
                bank_next    = buf1buf2n;
                tl_next      = vcount + 8'd1;
                mo_addr_next = {buf1buf2n, obj_byte(OBJ_BASE, 6'd0, OFS_Y)};
                state_next   = ST_ADDR_Y;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            i_reg        <= '0;
            k_reg        <= '0;
            tl_reg       <= '0;
            code_reg     <= '0;
            x_reg        <= '0;
            pix_reg      <= '0;
            row_reg      <= '0;
            bank_reg     <= 1'b0;
            lb_sel_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
            mo_addr_reg  <= '0;
            rom_addr_reg <= '0;
        end else if (clk_en) begin
            state_reg    <= state_next;
            i_reg        <= i_next;
            k_reg        <= k_next;
            tl_reg       <= tl_next;
            code_reg     <= code_next;
            x_reg        <= x_next;
            pix_reg      <= pix_next;
            row_reg      <= row_next;
            bank_reg     <= bank_next;
            lb_sel_reg   <= lb_sel_next;
            overrun_reg  <= overrun_next;
            mo_addr_reg  <= mo_addr_next;
            rom_addr_reg <= rom_addr_next;
        end
    end

    // Pixel offset within the object is 2k plus one for the right-hand nibble.
    assign pix_state = (state_reg == ST_PIX0) || (state_reg == ST_PIX1);
    assign nibble    = (state_reg == ST_PIX1) ? pix_reg[3:0] : pix_reg[7:4];
    assign x9        = {1'b0, x_reg} + {6'd0, k_reg, (state_reg == ST_PIX1)};

    // The pixel in flight is dropped when a new line aborts the scan.
    assign lb_we    = clk_en && !hblank_start && pix_state && (nibble != 4'd0) && !x9[8];
    assign lb_addr  = x9[7:0];
    assign lb_data  = nibble;
    assign lb_sel   = lb_sel_reg;
    assign overrun  = overrun_reg;
    assign mo_addr  = mo_addr_reg;
    assign rom_addr = rom_addr_reg;

endmodule

// File: tb/tb_mo_line_scheduler.sv
// Bench for mo_line_scheduler: directed and random lines compared against a
// per-line reference buffer computed from sprite RAM and picture ROM contents.
module tb_mo_line_scheduler;

    localparam int         NUM_OBJ  = 40;
    localparam logic [7:0] OBJ_BASE = 8'h10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        hblank_start;
    logic        vblank;
    logic [7:0]  vcount;
    logic        buf1buf2n;
    logic [8:0]  mo_addr;
    logic [7:0]  mo_data;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        lb_we;
    logic        lb_sel;
    logic [7:0]  lb_addr;
    logic [3:0]  lb_data;
    logic        busy;
    logic        overrun;

    mo_line_scheduler #(.NUM_OBJ(NUM_OBJ), .OBJ_BASE(OBJ_BASE)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_en       (clk_en),
        .hblank_start (hblank_start),
        .vblank       (vblank),
        .vcount       (vcount),
        .buf1buf2n    (buf1buf2n),
        .mo_addr      (mo_addr),
        .mo_data      (mo_data),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .lb_we        (lb_we),
        .lb_sel       (lb_sel),
        .lb_addr      (lb_addr),
        .lb_data      (lb_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:511];
    logic [7:0] rom [0:16383];
    logic [4:0] lb_mem [0:1][0:255];
    logic [4:0] exp_buf [0:255];
    int         exp_busy, exp_writes;
    int         busy_cnt, n_writes;
    int         n_checks = 0, n_errors = 0;
    logic       lb_sel_exp;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1 clk_en = ~clk_en;
        end
    end

    // Synchronous memories: address taken on an enabled edge, data one enabled cycle later.
    initial begin
        logic [8:0]  mo_a;
        logic [13:0] rom_a;
        mo_data  = 8'd0;
        rom_data = 8'd0;
        forever begin
            @(posedge clk);
            if (clk_en) begin
                mo_a  = mo_addr;
                rom_a = rom_addr;
                #1;
                mo_data  = ram[mo_a];
                rom_data = rom[rom_a];
            end
        end
    end

    always @(negedge clk) begin
        if (clk_en) begin
            if (busy) busy_cnt++;
            if (lb_we) begin
                lb_mem[lb_sel][lb_addr] = {1'b1, lb_data};
                n_writes++;
            end
        end else begin
            check("we_hold", int'(lb_we), 0);
        end
    end

    task automatic tick();
        do @(posedge clk); while (!clk_en);
        #2;
    endtask

    task automatic set_obj(input logic bank, input int i, input logic [7:0] code,
                           input logic [7:0] y, input logic [7:0] x);
        int a;
        a = (bank ? 256 : 0) + int'(OBJ_BASE) + 4 * i;
        ram[a]     = code;
        ram[a + 1] = y;
        ram[a + 2] = 8'($urandom);
        ram[a + 3] = x;
    endtask

    task automatic clear_bank(input logic bank, input logic [7:0] tl);
        for (int i = 0; i < NUM_OBJ; i++)
            set_obj(bank, i, 8'($urandom), tl + 8'd100, 8'($urandom));
    endtask

    task automatic randomize_bank(input logic bank, input logic [7:0] tl);
        for (int i = 0; i < NUM_OBJ; i++) begin
            logic [7:0] y;
            if ($urandom_range(0, 3) == 0) y = tl - 8'($urandom_range(0, 15));
            else                           y = tl - 8'($urandom_range(16, 255));
            set_obj(bank, i, 8'($urandom), y, 8'($urandom));
        end
    endtask

    // Reference: objects in index order, later ones overwrite earlier ones.
    task automatic model_line(input logic [7:0] vc, input logic bank);
        logic [7:0] tl, y, x, code, row8, b;
        logic [3:0] nib;
        int base, px;
        tl = vc + 8'd1;
        exp_busy = 0;
        exp_writes = 0;
        for (int a = 0; a < 256; a++) exp_buf[a] = 5'd0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            base = (bank ? 256 : 0) + int'(OBJ_BASE) + 4 * i;
            y    = ram[base + 1];
            row8 = tl - y;
            if (row8 < 8'd16) begin
                exp_busy += 17;
                code = ram[base];
                x    = ram[base + 3];
                for (int p = 0; p < 8; p++) begin
                    b   = rom[int'(code) * 64 + int'(row8) * 4 + p / 2];
                    nib = (p % 2 == 0) ? b[7:4] : b[3:0];
                    px  = int'(x) + p;
                    if (nib != 4'd0 && px < 256) begin
                        exp_buf[px] = {1'b1, nib};
                        exp_writes++;
                    end
                end
            end else begin
                exp_busy += 2;
            end
        end
    endtask

    task automatic start_line(input logic [7:0] vc, input logic bank, input logic exp_ov);
        model_line(vc, bank);
        vcount       = vc;
        buf1buf2n    = bank;
        vblank       = 1'b0;
        hblank_start = 1'b1;
        tick();
        hblank_start = 1'b0;
        lb_sel_exp   = !lb_sel_exp;
        for (int a = 0; a < 256; a++) lb_mem[lb_sel_exp][a] = 5'd0;
        busy_cnt = 0;
        n_writes = 0;
        check("lb_sel", int'(lb_sel), int'(lb_sel_exp));
        check("overrun", int'(overrun), int'(exp_ov));
        check("busy_start", int'(busy), 1);
        check("mo_addr_start", int'(mo_addr), int'({bank, OBJ_BASE + 8'd1}));
    endtask

    task automatic finish_line(input string name);
        for (int t = 0; t < 4000 && busy; t++) tick();
        check({name, "_done"}, int'(busy), 0);
        check({name, "_cycles"}, busy_cnt, exp_busy);
        check({name, "_writes"}, n_writes, exp_writes);
        check({name, "_sel_hold"}, int'(lb_sel), int'(lb_sel_exp));
        for (int a = 0; a < 256; a++)
            check($sformatf("%s_pix%0d", name, a), int'(lb_mem[lb_sel_exp][a]), int'(exp_buf[a]));
        $display("line %s: %0d cycles, %0d writes", name, busy_cnt, n_writes);
    endtask

    initial begin
        int xs [8] = '{20, 21, 22, 23, 24, 25, 26, 27};
        int vs [8] = '{17, 18, 19, 20, 0, 0, 21, 22};
        logic [8:0] held_addr;
        logic [7:0] vc;
        logic       bk;

        reset_n      = 1'b0;
        hblank_start = 1'b0;
        vblank       = 1'b0;
        vcount       = 8'd0;
        buf1buf2n    = 1'b0;
        lb_sel_exp   = 1'b0;
        busy_cnt     = 0;
        n_writes     = 0;
        for (int a = 0; a < 16384; a++) rom[a] = 8'($urandom);
        for (int a = 0; a < 512; a++) ram[a] = 8'($urandom);
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) lb_mem[b][a] = 5'd0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_lb_sel", int'(lb_sel), 0);
        check("rst_lb_we", int'(lb_we), 0);
        check("rst_mo_addr", int'(mo_addr), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_lb_addr", int'(lb_addr), 0);
        check("rst_lb_data", int'(lb_data), 0);
        #1 reset_n = 1'b1;
        tick();

        // Single hit: object 5, code 3, ROM row 1 = 12 34 00 56.
        clear_bank(1'b0, 8'd11);
        set_obj(1'b0, 5, 8'd3, 8'd10, 8'd20);
        rom[3 * 64 + 4] = 8'h12; rom[3 * 64 + 5] = 8'h34;
        rom[3 * 64 + 6] = 8'h00; rom[3 * 64 + 7] = 8'h56;
        start_line(8'd10, 1'b0, 1'b0);
        finish_line("one_hit");
        check("one_hit_95", busy_cnt, 95);
        for (int n = 0; n < 8; n++)
            check($sformatf("one_hit_x%0d", xs[n]), int'(lb_mem[lb_sel_exp][xs[n]]), vs[n]);

        // Right-edge clipping without wrap.
        clear_bank(1'b0, 8'd11);
        set_obj(1'b0, 0, 8'd4, 8'd10, 8'd252);
        rom[4 * 64 + 4] = 8'h11; rom[4 * 64 + 5] = 8'h22;
        rom[4 * 64 + 6] = 8'h33; rom[4 * 64 + 7] = 8'h44;
        start_line(8'd10, 1'b0, 1'b0);
        finish_line("clip");
        check("clip_writes4", n_writes, 4);
        check("clip_x255", int'(lb_mem[lb_sel_exp][255]), 18);
        for (int a = 0; a < 4; a++)
            check($sformatf("clip_nowrap%0d", a), int'(lb_mem[lb_sel_exp][a]), 0);

        // Overlap: the higher index wins.
        clear_bank(1'b0, 8'd11);
        set_obj(1'b0, 2, 8'd5, 8'd10, 8'd40);
        set_obj(1'b0, 9, 8'd6, 8'd10, 8'd40);
        for (int c = 0; c < 4; c++) begin
            rom[5 * 64 + 4 + c] = 8'h77;
            rom[6 * 64 + 4 + c] = 8'h99;
        end
        start_line(8'd10, 1'b0, 1'b0);
        finish_line("overlap");
        check("overlap_x40", int'(lb_mem[lb_sel_exp][40]), 25);

        // hblank landing on the edge that enters DONE is not an overrun; one edge earlier is.
        clear_bank(1'b1, 8'd51);
        start_line(8'd50, 1'b1, 1'b0);
        repeat (79) tick();
        start_line(8'd50, 1'b1, 1'b0);
        repeat (78) tick();
        start_line(8'd50, 1'b1, 1'b1);
        finish_line("miss_scan");
        check("miss_scan_80", busy_cnt, 80);

        // Twenty hits overrun a 320-cycle line; the next clean line clears overrun.
        clear_bank(1'b0, 8'd101);
        for (int i = 0; i < 20; i++)
            set_obj(1'b0, i, 8'(7 + i), 8'(101 - (i % 16)), 8'(i * 12));
        start_line(8'd100, 1'b0, 1'b0);
        repeat (320) tick();
        start_line(8'd100, 1'b0, 1'b1);
        finish_line("ovr_rescan");
        start_line(8'd100, 1'b0, 1'b0);
        finish_line("ovr_clean");

        // Random lines in both banks.
        for (int n = 0; n < 8; n++) begin
            vc = 8'($urandom);
            bk = 1'($urandom);
            randomize_bank(1'b0, vc + 8'd1);
            randomize_bank(1'b1, vc + 8'd1);
            start_line(vc, bk, 1'b0);
            finish_line($sformatf("rand%0d", n));
        end

        // vblank: lb_sel toggles, no scan, no sprite RAM access.
        held_addr    = mo_addr;
        vblank       = 1'b1;
        hblank_start = 1'b1;
        tick();
        hblank_start = 1'b0;
        lb_sel_exp   = !lb_sel_exp;
        check("vbl_lb_sel", int'(lb_sel), int'(lb_sel_exp));
        check("vbl_busy", int'(busy), 0);
        check("vbl_overrun", int'(overrun), 0);
        repeat (5) tick();
        check("vbl_mo_addr", int'(mo_addr), int'(held_addr));
        check("vbl_busy_later", int'(busy), 0);
        vblank = 1'b0;

        // Asynchronous reset while the first pixel of object 0 is being written.
        clear_bank(1'b0, 8'd11);
        set_obj(1'b0, 0, 8'd4, 8'd10, 8'd100);
        start_line(8'd10, 1'b0, 1'b0);
        repeat (6) tick();
        @(posedge clk);
        #2;
        check("pix0_we", int'(lb_we), 1);
        check("pix0_addr", int'(lb_addr), 100);
        check("pix0_data", int'(lb_data), 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_lb_we", int'(lb_we), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_lb_sel", int'(lb_sel), 0);
        check("arst_overrun", int'(overrun), 0);
        lb_sel_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) tick();
        check("arst_idle", int'(busy), 0);
        start_line(8'd10, 1'b0, 1'b0);
        finish_line("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
